// File: rtl/reservation_station_pkg.sv
// Shared widths, the entry payload type and the tag-match helper for the
// reservation station. Tag 0 means "operand value already present".
package reservation_station_pkg;

    localparam int RS_WIDTH        = 4;
    localparam int RS_SIZE         = 1 << RS_WIDTH;
    localparam int ROB_WIDTH       = 5;
    localparam int ID_WIDTH        = 32;
    localparam int INST_TYPE_WIDTH = 6;
    localparam int ADDRESS_WIDTH   = 32;

    localparam logic [ROB_WIDTH-1:0]       TAG_NONE = '0;
    localparam logic [INST_TYPE_WIDTH-1:0] OP_NOP   = '0;

    typedef struct packed {
        logic [INST_TYPE_WIDTH-1:0] opcode;
        logic [ID_WIDTH-1:0]        a;
        logic [ROB_WIDTH-1:0]       qj;
        logic [ID_WIDTH-1:0]        vj;
        logic [ROB_WIDTH-1:0]       qk;
        logic [ID_WIDTH-1:0]        vk;
        logic [ROB_WIDTH-1:0]       dest;
        logic [ADDRESS_WIDTH-1:0]   pc;
    } rs_entry_t;

    // A broadcast satisfies an operand only if the operand is still waiting on
    // exactly that producer.
    function automatic logic tag_hit(input logic en,
                                     input logic [ROB_WIDTH-1:0] q,
                                     input logic [ROB_WIDTH-1:0] tag);
        return en && (q != TAG_NONE) && (q == tag);
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Picks one requester out of N. A requester j blocks requester i when j is
// marked older in the age matrix, or, in lowest-first mode, when j < i.
// Used for both the issue pick and the free-entry pick.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int N            = 16,
    parameter int W            = 4,
    parameter bit LOWEST_FIRST = 1'b1
) (
    input  logic [N-1:0]   req,
    input  logic [N*N-1:0] age,
    output logic [W-1:0]   idx,
    output logic           valid
);

    logic [N-1:0] grant;

    // Grant every requester that no other requester outranks; exactly one survives.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && req[j] && (age[i*N+j] || (LOWEST_FIRST && (j < i)))) begin
                    blocked = 1'b1;
                end
            end
            grant[i] = req[i] && !blocked;
        end
    end

    // Encode the single grant as an index.
    always_comb begin
        idx   = '0;
        valid = |grant;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo issue queue: holds dispatched ALU/branch ops, wakes operands from
// the ALU and LSB result buses, issues one ready op per cycle to the ALU and
// hands the dispatcher the lowest free entry index.
// Build option: define RS_OLDEST_FIRST_EN to issue the oldest ready op via an
// age matrix; otherwise the lowest-index ready op issues.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rob_rs_clear_in,
    input  logic                       dispatcher_rs_en_in,
    input  logic [INST_TYPE_WIDTH-1:0] dispatcher_rs_opcode_in,
    input  logic [ID_WIDTH-1:0]        dispatcher_rs_a_in,
    input  logic [ROB_WIDTH-1:0]       dispatcher_rs_qj_in,
    input  logic [ROB_WIDTH-1:0]       dispatcher_rs_qk_in,
    input  logic [ID_WIDTH-1:0]        dispatcher_rs_vj_in,
    input  logic [ID_WIDTH-1:0]        dispatcher_rs_vk_in,
    input  logic [ROB_WIDTH-1:0]       dispatcher_rs_dest_in,
    input  logic [ADDRESS_WIDTH-1:0]   dispatcher_rs_pc_in,
    output logic [RS_WIDTH-1:0]        rs_dispatcher_r_out,
    output logic                       rs_dispatcher_full_out,
    input  logic                       alu_cdb_en_in,
    input  logic [ROB_WIDTH-1:0]       alu_cdb_tag_in,
    input  logic [ID_WIDTH-1:0]        alu_cdb_value_in,
    input  logic                       lsb_cdb_en_in,
    input  logic [ROB_WIDTH-1:0]       lsb_cdb_tag_in,
    input  logic [ID_WIDTH-1:0]        lsb_cdb_value_in,
    output logic                       rs_alu_en_out,
    output logic [INST_TYPE_WIDTH-1:0] rs_alu_opcode_out,
    output logic [ID_WIDTH-1:0]        rs_alu_vj_out,
    output logic [ID_WIDTH-1:0]        rs_alu_vk_out,
    output logic [ID_WIDTH-1:0]        rs_alu_a_out,
    output logic [ROB_WIDTH-1:0]       rs_alu_dest_out,
    output logic [ADDRESS_WIDTH-1:0]   rs_alu_pc_out
);

    logic [RS_SIZE-1:0]         busy;
    rs_entry_t                  ent [RS_SIZE];
    logic [RS_SIZE-1:0]         ready;
    logic [RS_SIZE-1:0]         free_req;
    logic [RS_SIZE*RS_SIZE-1:0] age_sel;
    logic [RS_WIDTH-1:0]        free_idx;
    logic                       free_valid;
    logic [RS_WIDTH-1:0]        iss_idx;
    logic                       iss_valid;
    logic                       disp_fire;
    rs_entry_t                  disp_entry;

    // Readiness and free slots come only from registered state, so a wakeup or
    // dispatch is never selected in the same cycle it lands.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (ent[i].qj == TAG_NONE) && (ent[i].qk == TAG_NONE);
        end
        free_req = ~busy;
    end

    rs_select #(.N(RS_SIZE), .W(RS_WIDTH), .LOWEST_FIRST(1'b1)) u_free_select (
        .req   (free_req),
        .age   ('0),
        .idx   (free_idx),
        .valid (free_valid)
    );

`ifdef RS_OLDEST_FIRST_EN
    rs_select #(.N(RS_SIZE), .W(RS_WIDTH), .LOWEST_FIRST(1'b0)) u_issue_select (
        .req   (ready),
        .age   (age_sel),
        .idx   (iss_idx),
        .valid (iss_valid)
    );
`else
    assign age_sel = '0;

    rs_select #(.N(RS_SIZE), .W(RS_WIDTH), .LOWEST_FIRST(1'b1)) u_issue_select (
        .req   (ready),
        .age   (age_sel),
        .idx   (iss_idx),
        .valid (iss_valid)
    );
`endif

    assign rs_dispatcher_r_out    = free_idx;
    assign rs_dispatcher_full_out = !free_valid;
    assign disp_fire              = dispatcher_rs_en_in && free_valid;

    // Build the dispatched entry, capturing any result broadcast this same cycle
    // so the operand does not wait forever on a tag that has already gone by.
    always_comb begin
        disp_entry.opcode = dispatcher_rs_opcode_in;
        disp_entry.a      = dispatcher_rs_a_in;
        disp_entry.dest   = dispatcher_rs_dest_in;
        disp_entry.pc     = dispatcher_rs_pc_in;
        disp_entry.qj     = dispatcher_rs_qj_in;
        disp_entry.vj     = dispatcher_rs_vj_in;
        disp_entry.qk     = dispatcher_rs_qk_in;
        disp_entry.vk     = dispatcher_rs_vk_in;
        if (tag_hit(alu_cdb_en_in, dispatcher_rs_qj_in, alu_cdb_tag_in)) begin
            disp_entry.qj = TAG_NONE;
            disp_entry.vj = alu_cdb_value_in;
        end else if (tag_hit(lsb_cdb_en_in, dispatcher_rs_qj_in, lsb_cdb_tag_in)) begin
            disp_entry.qj = TAG_NONE;
            disp_entry.vj = lsb_cdb_value_in;
        end
        if (tag_hit(alu_cdb_en_in, dispatcher_rs_qk_in, alu_cdb_tag_in)) begin
            disp_entry.qk = TAG_NONE;
            disp_entry.vk = alu_cdb_value_in;
        end else if (tag_hit(lsb_cdb_en_in, dispatcher_rs_qk_in, lsb_cdb_tag_in)) begin
            disp_entry.qk = TAG_NONE;
            disp_entry.vk = lsb_cdb_value_in;
        end
    end

    // Entry storage, wakeup, dispatch and issue; flush outranks everything else.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy              <= '0;
            rs_alu_en_out     <= 1'b0;
            rs_alu_opcode_out <= OP_NOP;
            rs_alu_vj_out     <= '0;
            rs_alu_vk_out     <= '0;
            rs_alu_a_out      <= '0;
            rs_alu_dest_out   <= '0;
            rs_alu_pc_out     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
        end else if (!rdy_in) begin
            rs_alu_en_out <= 1'b0;
        end else if (rob_rs_clear_in) begin
            busy          <= '0;
            rs_alu_en_out <= 1'b0;
        end else begin
            rs_alu_en_out <= iss_valid;
            if (iss_valid) begin
                rs_alu_opcode_out <= ent[iss_idx].opcode;
                rs_alu_vj_out     <= ent[iss_idx].vj;
                rs_alu_vk_out     <= ent[iss_idx].vk;
                rs_alu_a_out      <= ent[iss_idx].a;
                rs_alu_dest_out   <= ent[iss_idx].dest;
                rs_alu_pc_out     <= ent[iss_idx].pc;
                busy[iss_idx]     <= 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (tag_hit(alu_cdb_en_in, ent[i].qj, alu_cdb_tag_in)) begin
                    ent[i].qj <= TAG_NONE;
                    ent[i].vj <= alu_cdb_value_in;
                end else if (tag_hit(lsb_cdb_en_in, ent[i].qj, lsb_cdb_tag_in)) begin
                    ent[i].qj <= TAG_NONE;
                    ent[i].vj <= lsb_cdb_value_in;
                end
                if (tag_hit(alu_cdb_en_in, ent[i].qk, alu_cdb_tag_in)) begin
                    ent[i].qk <= TAG_NONE;
                    ent[i].vk <= alu_cdb_value_in;
                end else if (tag_hit(lsb_cdb_en_in, ent[i].qk, lsb_cdb_tag_in)) begin
                    ent[i].qk <= TAG_NONE;
                    ent[i].vk <= lsb_cdb_value_in;
                end
            end
            // The free slot is never the issuing slot, so these writes cannot collide.
            if (disp_fire) begin
                ent[free_idx]  <= disp_entry;
                busy[free_idx] <= 1'b1;
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_SIZE*RS_SIZE-1:0] age;

    assign age_sel = age;

    // age[i*N+j] set means j was already waiting when i arrived. A newly loaded
    // slot is also wiped from every other row so stale history from its
    // previous occupant cannot make it look old.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            age <= '0;
        end else if (rdy_in) begin
            if (rob_rs_clear_in) begin
                age <= '0;
            end else if (disp_fire) begin
                for (int k = 0; k < RS_SIZE; k++) begin
                    age[k*RS_SIZE + int'(free_idx)] <= 1'b0;
                end
                for (int j = 0; j < RS_SIZE; j++) begin
                    age[int'(free_idx)*RS_SIZE + j] <= busy[j];
                end
            end
        end
    end
`endif

endmodule
